// File: rtl/sccb_slave_model.sv
// SCCB/I2C responder modelling the OV5640 control port: 7-bit device address,
// 16-bit register pointer, 8-bit data; writes leave as strobes, reads come from an external store.
module sccb_slave_model #(
   parameter logic [6:0] DEV_ADDR = 7'h3C,
   parameter int         FILT_LEN = 3
) (
   input  logic        clk_10M,
   input  logic        camera_rstn,
   input  logic        i2c_sclk,
   input  logic        i2c_sdat_i,
   output logic        i2c_sdat_oe,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        busy,
   output logic [8:0]  wr_cnt
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_ACK_DEV, S_AHI, S_ACK_AHI, S_ALO, S_ACK_ALO,
      S_WDAT, S_ACK_WDAT, S_RDAT, S_MACK, S_IGNORE
   } state_t;

   // Line index 0 is SCL, index 1 is SDA.
   logic [1:0]    r_meta, r_sync, r_filt, r_filt_d;
   logic [CW-1:0] r_cnt [2];

   state_t      r_state;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_addr_hi;
   logic [15:0] r_ptr;
   logic        r_rw;
   logic        r_ack_phase;
   logic        r_oe;
   logic        r_wr_en;
   logic [15:0] r_wr_addr;
   logic [7:0]  r_wr_data;
   logic        r_busy;
   logic [8:0]  r_wr_cnt;

   logic       w_sda;
   logic       w_scl_rise, w_scl_fall;
   logic       w_start, w_stop;
   logic       w_last_bit;
   logic [7:0] w_byte;

   // NOTE: synchronizer and filter flops reset to the idle bus level (1) so that
   // reset release never looks like a START or an SCL edge.
   always_ff @(posedge clk_10M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         r_meta   <= '1;
         r_sync   <= '1;
         r_filt   <= '1;
         r_filt_d <= '1;
         for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      end else begin
         r_meta   <= {i2c_sdat_i, i2c_sclk};
         r_sync   <= r_meta;
         r_filt_d <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (r_sync[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CW'(FILT_LEN - 1)) begin
               r_filt[i] <= r_sync[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_sda      = r_filt[1];
   assign w_scl_rise =  r_filt[0] & ~r_filt_d[0];
   assign w_scl_fall = ~r_filt[0] &  r_filt_d[0];
   assign w_start    =  r_filt[0] &  r_filt_d[1] & ~r_filt[1];
   assign w_stop     =  r_filt[0] & ~r_filt_d[1] &  r_filt[1];
   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_last_bit = (r_bit_cnt == 3'd7);

   always_ff @(posedge clk_10M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_addr_hi   <= '0;
         r_ptr       <= '0;
         r_rw        <= 1'b0;
         r_ack_phase <= 1'b0;
         r_oe        <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_wr_cnt    <= '0;
      end else begin
         // NOTE: non-blocking default makes wr_en a one-cycle strobe; any branch below
         // that raises it overrides this for exactly one clock.
         r_wr_en <= 1'b0;
         if (w_start) begin
            r_state     <= S_DEV;
            r_bit_cnt   <= '0;
            r_ack_phase <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b1;
         end else if (w_stop) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_ack_phase <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               S_DEV, S_AHI, S_ALO, S_WDAT: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last_bit) begin
                        case (r_state)
                           S_DEV: begin
                              if (w_byte[7:1] == DEV_ADDR) begin
                                 r_rw    <= w_byte[0];
                                 r_state <= S_ACK_DEV;
                              end else begin
                                 r_state <= S_IGNORE;
                              end
                           end
                           S_AHI: begin
                              r_addr_hi <= w_byte;
                              r_state   <= S_ACK_AHI;
                           end
                           S_ALO: begin
                              r_ptr   <= {r_addr_hi, w_byte};
                              r_state <= S_ACK_ALO;
                           end
                           default: begin
                              r_wr_en   <= 1'b1;
                              r_wr_addr <= r_ptr;
                              r_wr_data <= w_byte;
                              if (r_wr_cnt != 9'h1FF) r_wr_cnt <= r_wr_cnt + 9'd1;
                              r_ptr     <= r_ptr + 16'd1;
                              r_state   <= S_ACK_WDAT;
                           end
                        endcase
                     end
                  end
               end

               // First SCL fall pulls SDA low, the second one ends the ACK clock.
               S_ACK_DEV, S_ACK_AHI, S_ACK_ALO, S_ACK_WDAT: begin
                  if (w_scl_fall) begin
                     if (!r_ack_phase) begin
                        r_oe        <= 1'b1;
                        r_ack_phase <= 1'b1;
                     end else begin
                        r_ack_phase <= 1'b0;
                        r_oe        <= 1'b0;
                        r_bit_cnt   <= '0;
                        case (r_state)
                           S_ACK_DEV: begin
                              if (r_rw) begin
                                 r_shift <= rd_data;
                                 r_oe    <= ~rd_data[7];
                                 r_state <= S_RDAT;
                              end else begin
                                 r_state <= S_AHI;
                              end
                           end
                           S_ACK_AHI: r_state <= S_ALO;
                           default:   r_state <= S_WDAT;
                        endcase
                     end
                  end
               end

               S_RDAT: begin
                  if (w_scl_rise) begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last_bit) r_state <= S_MACK;
                  end else if (w_scl_fall) begin
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_oe    <= ~r_shift[6];
                  end
               end

               // r_ack_phase marks a master ACK already seen; the fall that follows reloads.
               S_MACK: begin
                  if (w_scl_rise) begin
                     if (!w_sda) begin
                        r_ptr       <= r_ptr + 16'd1;
                        r_ack_phase <= 1'b1;
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end else if (w_scl_fall) begin
                     if (r_ack_phase) begin
                        r_ack_phase <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_shift     <= rd_data;
                        r_oe        <= ~rd_data[7];
                        r_state     <= S_RDAT;
                     end else begin
                        r_oe <= 1'b0;
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

   assign i2c_sdat_oe = r_oe;
   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign rd_addr     = r_ptr;
   assign busy        = r_busy;
   assign wr_cnt      = r_wr_cnt;

endmodule
